inst_fetch: RTL

Instruction fetch stage sitting directly upstream of the 64-word instruction memory. It holds the program counter and drives the memory's word address. It captures the combinational instruction word returned in the same cycle into a 2-entry output FIFO, then hands {pc, instruction} pairs to decode over a valid/ready handshake. Branch/jump redirects flush the FIFO and reload the PC; a misaligned redirect target latches a sticky fault and stops fetching.

---
 rtl/inst_fetch.sv | 100 ++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, addresses the instruction memory and
// buffers fetched {pc, inst} pairs in a 2-entry FIFO toward decode.
module inst_fetch #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  output logic              fault
);

  logic [31:0] pc_reg;
  logic [1:0]  count_reg;
  logic        fault_reg;
  logic [31:0] head_pc_reg;
  logic [31:0] head_inst_reg;
  logic [31:0] tail_pc_reg;
  logic [31:0] tail_inst_reg;

  logic pop;
  logic push;
  logic redirect_take;

  assign imem_addr = pc_reg[ADDR_W+1:2];
  assign out_valid = (count_reg != 2'd0);
  assign out_pc    = head_pc_reg;
  assign out_inst  = head_inst_reg;
  assign fault     = fault_reg;

  assign pop           = out_valid && out_ready;
  assign redirect_take = redirect_valid && !fault_reg;
  assign push          = !fault_reg && !redirect_valid && ((count_reg < 2'd2) || pop);

  // Two-slot shift FIFO: the head slot drives the outputs and keeps its last
  // value once drained, so out_pc/out_inst never go undefined.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg        <= RESET_PC;
      count_reg     <= 2'd0;
      fault_reg     <= 1'b0;
      head_pc_reg   <= 32'd0;
      head_inst_reg <= 32'd0;
      tail_pc_reg   <= 32'd0;
      tail_inst_reg <= 32'd0;
    end else if (redirect_take) begin
      count_reg <= 2'd0;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_reg <= redirect_pc;
      end else begin
        fault_reg <= 1'b1;
      end
    end else begin
      if (push) begin
        pc_reg <= pc_reg + 32'd4;
      end
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) begin
            head_pc_reg   <= pc_reg;
            head_inst_reg <= imem_data;
          end else begin
            tail_pc_reg   <= pc_reg;
            tail_inst_reg <= imem_data;
          end
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          if (count_reg == 2'd2) begin
            head_pc_reg   <= tail_pc_reg;
            head_inst_reg <= tail_inst_reg;
          end
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          // Count stays the same; the new word lands behind whatever remains.
          if (count_reg == 2'd2) begin
            head_pc_reg   <= tail_pc_reg;
            head_inst_reg <= tail_inst_reg;
            tail_pc_reg   <= pc_reg;
            tail_inst_reg <= imem_data;
          end else begin
            head_pc_reg   <= pc_reg;
            head_inst_reg <= imem_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
